// File: rtl/fx3_stream_arbiter.sv
// fx3_stream_arbiter
//   Time-shares the single FX3 slave-FIFO bus between the stream-OUT reader
//   (FX3 -> FPGA) and the stream-IN writer (FPGA -> FX3). Only one direction
//   is granted at a time. Each grant is preceded by a bus-turnaround gap and
//   followed by a drain phase. The drain phase waits, with a timeout, for the
//   granted engine to go idle.
//
// Ports
//   clk_100                  system clock
//   reset_                   asynchronous reset, active low
//   out_req / in_req         per-direction request (sink ready / source has data)
//   flagc_d / flaga_d        registered FX3 read-available / write-space flags
//   out_busy / in_busy       per-direction engine not idle
//   clr_err                  clears drain_timeout_err
//   stream_out_mode_selected enables the stream-OUT engine
//   stream_in_mode_selected  enables the stream-IN engine
//   faddr                    FX3 socket address
//   active_dir               00 none, 01 OUT, 10 IN
//   drain_timeout_err        sticky drain-timeout flag
module fx3_stream_arbiter #(
  parameter int         MAX_OUT_BURST = 1024,
  parameter int         MAX_IN_BURST  = 1024,
  parameter int         TURN_GAP      = 3,
  parameter int         DRAIN_TIMEOUT = 255,
  parameter logic [1:0] OUT_ADDR      = 2'b11,
  parameter logic [1:0] IN_ADDR       = 2'b00
) (
  input  logic       clk_100,
  input  logic       reset_,
  input  logic       out_req,
  input  logic       in_req,
  input  logic       flagc_d,
  input  logic       flaga_d,
  input  logic       out_busy,
  input  logic       in_busy,
  input  logic       clr_err,
  output logic       stream_out_mode_selected,
  output logic       stream_in_mode_selected,
  output logic [1:0] faddr,
  output logic [1:0] active_dir,
  output logic       drain_timeout_err
);

  localparam int MAX_BURST = (MAX_OUT_BURST > MAX_IN_BURST) ? MAX_OUT_BURST : MAX_IN_BURST;
  localparam int BW = $clog2(MAX_BURST);
  // Counters get one spare value so the terminal increment never wraps.
  localparam int GW = $clog2(TURN_GAP + 1);
  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [BW-1:0] OUT_LIM  = BW'(MAX_OUT_BURST - 1);
  localparam logic [BW-1:0] IN_LIM   = BW'(MAX_IN_BURST - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TURN_GAP - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DRAIN_TIMEOUT - 1);

  localparam logic DIR_OUT = 1'b0;
  localparam logic DIR_IN  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TURN   = 2'd1,
    S_ACTIVE = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            target_q, target_d;
  logic            last_dir_q, last_dir_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [1:0]      faddr_q, faddr_d;
  logic            out_sel_q, out_sel_d;
  logic            in_sel_q, in_sel_d;
  logic [1:0]      active_dir_q, active_dir_d;
  logic            err_q, err_d;

  logic out_elig, in_elig, idle_target;
  logic own_req, other_elig, own_busy, burst_at_lim, tmo_hit, tmo_set;

  assign out_elig = out_req & flagc_d;
  assign in_elig  = in_req & flaga_d;

  // Contention goes to the direction that did not hold the bus last.
  assign idle_target = (out_elig && in_elig) ? ~last_dir_q :
                       (out_elig ? DIR_OUT : DIR_IN);

  assign own_req      = (target_q == DIR_IN) ? in_req   : out_req;
  assign other_elig   = (target_q == DIR_IN) ? out_elig : in_elig;
  assign own_busy     = (target_q == DIR_IN) ? in_busy  : out_busy;
  assign burst_at_lim = burst_cnt_q == ((target_q == DIR_IN) ? IN_LIM : OUT_LIM);
  assign tmo_hit      = tmo_cnt_q == TMO_LAST;
  // Idle engine wins over an expiring timeout in the same cycle.
  assign tmo_set      = (state_q == S_DRAIN) && own_busy && tmo_hit;

  // State register and all registered outputs.
  always_ff @(posedge clk_100 or negedge reset_) begin
    if (!reset_) begin
      state_q      <= S_IDLE;
      target_q     <= DIR_OUT;
      last_dir_q   <= DIR_IN;
      gap_cnt_q    <= '0;
      burst_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      faddr_q      <= OUT_ADDR;
      out_sel_q    <= 1'b0;
      in_sel_q     <= 1'b0;
      active_dir_q <= 2'b00;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      last_dir_q   <= last_dir_d;
      gap_cnt_q    <= gap_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      faddr_q      <= faddr_d;
      out_sel_q    <= out_sel_d;
      in_sel_q     <= in_sel_d;
      active_dir_q <= active_dir_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (out_elig || in_elig) state_d = S_TURN;
      S_TURN:   if (gap_cnt_q == GAP_LAST) state_d = S_ACTIVE;
      // Flag stalls are left to the engine; only req or fairness ends a grant.
      S_ACTIVE: if (!own_req || (burst_at_lim && other_elig)) state_d = S_DRAIN;
      S_DRAIN:  if (!own_busy || tmo_hit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters and next values of the registered outputs.
  always_comb begin
    target_d    = target_q;
    last_dir_d  = last_dir_q;
    gap_cnt_d   = gap_cnt_q;
    burst_cnt_d = burst_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    faddr_d     = faddr_q;
    case (state_q)
      S_IDLE: begin
        if (state_d == S_TURN) begin
          target_d  = idle_target;
          faddr_d   = (idle_target == DIR_IN) ? IN_ADDR : OUT_ADDR;
          gap_cnt_d = '0;
        end
      end
      S_TURN: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (state_d == S_ACTIVE) begin
          burst_cnt_d = '0;
          last_dir_d  = target_q;
        end
      end
      S_ACTIVE: begin
        if (!burst_at_lim) burst_cnt_d = burst_cnt_q + 1'b1;
        if (state_d == S_DRAIN) tmo_cnt_d = '0;
      end
      S_DRAIN: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
      default: begin
        gap_cnt_d = '0;
      end
    endcase

    out_sel_d = (state_d == S_ACTIVE) && (target_q == DIR_OUT);
    in_sel_d  = (state_d == S_ACTIVE) && (target_q == DIR_IN);

    if (state_d == S_ACTIVE)     active_dir_d = {target_q, ~target_q};
    else if (state_d == S_DRAIN) active_dir_d = active_dir_q;
    else                         active_dir_d = 2'b00;

    // Set has priority over clear.
    if (tmo_set)      err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
    else              err_d = err_q;
  end

  assign stream_out_mode_selected = out_sel_q;
  assign stream_in_mode_selected  = in_sel_q;
  assign faddr                    = faddr_q;
  assign active_dir               = active_dir_q;
  assign drain_timeout_err        = err_q;

endmodule

// File: tb/tb_fx3_stream_arbiter.sv
module tb_fx3_stream_arbiter;

  localparam int MAXB = 8;
  localparam int TGAP = 3;
  localparam int TMO  = 4;

  logic       clk_100 = 1'b0;
  logic       reset_  = 1'b0;
  logic       out_req = 1'b0, in_req = 1'b0;
  logic       flagc_d = 1'b0, flaga_d = 1'b0;
  logic       out_busy = 1'b0, in_busy = 1'b0;
  logic       clr_err = 1'b0;
  logic       stream_out_mode_selected, stream_in_mode_selected;
  logic [1:0] faddr, active_dir;
  logic       drain_timeout_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] dir;
    logic [1:0] addr;
  } grant_t;
  grant_t exp_q[$];

  fx3_stream_arbiter #(
    .MAX_OUT_BURST(MAXB), .MAX_IN_BURST(MAXB), .TURN_GAP(TGAP),
    .DRAIN_TIMEOUT(TMO), .OUT_ADDR(2'b11), .IN_ADDR(2'b00)
  ) dut (
    .clk_100(clk_100), .reset_(reset_),
    .out_req(out_req), .in_req(in_req),
    .flagc_d(flagc_d), .flaga_d(flaga_d),
    .out_busy(out_busy), .in_busy(in_busy),
    .clr_err(clr_err),
    .stream_out_mode_selected(stream_out_mode_selected),
    .stream_in_mode_selected(stream_in_mode_selected),
    .faddr(faddr), .active_dir(active_dir),
    .drain_timeout_err(drain_timeout_err)
  );

  always #5 clk_100 = ~clk_100;

  // Mode selects must never both be high.
  always @(negedge clk_100) begin
    if (reset_) begin
      checks++;
      if (stream_out_mode_selected && stream_in_mode_selected) begin
        errors++;
        $display("FAIL mutex: out_sel=1 in_sel=1, required at most one");
      end
    end
  end

  task automatic tick;
    @(posedge clk_100);
    #1;
  endtask

  task automatic do_reset;
    out_req = 0; in_req = 0; flagc_d = 0; flaga_d = 0;
    out_busy = 0; in_busy = 0; clr_err = 0;
    reset_ = 0;
    @(posedge clk_100);
    @(posedge clk_100);
    @(negedge clk_100);
    reset_ = 1;
  endtask

  task automatic wait_grant(output logic [1:0] dir, output bit ok);
    ok  = 0;
    dir = 2'b00;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (stream_out_mode_selected || stream_in_mode_selected) begin
        dir = {stream_in_mode_selected, stream_out_mode_selected};
        ok  = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    out_req = 1; flagc_d = 1; in_req = 1; flaga_d = 1;
    reset_ = 0;
    @(posedge clk_100);
    #1;
    checks++;
    if ({stream_out_mode_selected, stream_in_mode_selected, faddr, active_dir, drain_timeout_err} !== 7'b0011000) begin
      errors++;
      $display("FAIL reset_values: got out=%b in=%b faddr=%b dir=%b err=%b, expected 0 0 11 00 0",
               stream_out_mode_selected, stream_in_mode_selected, faddr, active_dir, drain_timeout_err);
    end
    do_reset();
    tick();
    checks++;
    if ({stream_out_mode_selected, stream_in_mode_selected, faddr, active_dir} !== 6'b001100) begin
      errors++;
      $display("FAIL reset_release: got out=%b in=%b faddr=%b dir=%b, expected 0 0 11 00",
               stream_out_mode_selected, stream_in_mode_selected, faddr, active_dir);
    end
  endtask

  task automatic test_out_only;
    grant_t e;
    int bad;
    do_reset();
    out_req = 1; flagc_d = 1;
    exp_q.push_back('{dir: 2'b01, addr: 2'b11});
    for (int i = 1; i <= TGAP; i++) begin
      tick();
      checks++;
      if (stream_out_mode_selected !== 1'b0 || faddr !== 2'b11) begin
        errors++;
        $display("FAIL out_only_turn%0d: got sel=%b faddr=%b, expected sel=0 faddr=11",
                 i, stream_out_mode_selected, faddr);
      end
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (stream_out_mode_selected !== 1'b1 || active_dir !== e.dir || faddr !== e.addr) begin
      errors++;
      $display("FAIL out_only_grant: got sel=%b dir=%b faddr=%b, expected sel=1 dir=%b faddr=%b",
               stream_out_mode_selected, active_dir, faddr, e.dir, e.addr);
    end
    bad = 0;
    for (int i = 0; i < 3 * MAXB; i++) begin
      tick();
      if (stream_out_mode_selected !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL out_only_hold: sel dropped in %0d cycles, expected 0", bad);
    end
  endtask

  task automatic test_both_eligible;
    grant_t e;
    logic [1:0] sel, cur;
    bit granted, first;
    int len, gap, busy_left;
    do_reset();
    out_req = 1; flagc_d = 1; in_req = 1; flaga_d = 1;
    exp_q.push_back('{dir: 2'b01, addr: 2'b11});
    exp_q.push_back('{dir: 2'b10, addr: 2'b00});
    exp_q.push_back('{dir: 2'b01, addr: 2'b11});
    exp_q.push_back('{dir: 2'b10, addr: 2'b00});
    granted = 0; first = 1; len = 0; gap = 0; busy_left = 0; cur = 2'b00;
    for (int t = 0; t < 300 && (exp_q.size() > 0 || granted); t++) begin
      tick();
      sel = {stream_in_mode_selected, stream_out_mode_selected};
      if (sel != 2'b00) begin
        if (!granted) begin
          granted = 1; len = 0; cur = sel;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL both_extra_grant: got dir=%b, expected none", sel);
          end else begin
            e = exp_q.pop_front();
            checks++;
            if (sel !== e.dir || active_dir !== e.dir || faddr !== e.addr) begin
              errors++;
              $display("FAIL both_grant: got sel=%b dir=%b faddr=%b, expected %b %b %b",
                       sel, active_dir, faddr, e.dir, e.dir, e.addr);
            end
            // DRAIN (busy 2 + 1) + IDLE 1 + TURN 3
            if (!first) begin
              checks++;
              if (gap != 7) begin
                errors++;
                $display("FAIL both_gap: got %0d idle cycles, expected 7", gap);
              end
            end
            first = 0;
          end
        end
        len++;
      end else begin
        if (granted) begin
          granted = 0; gap = 0; busy_left = 2;
          checks++;
          if (len != MAXB || active_dir !== cur) begin
            errors++;
            $display("FAIL both_burst: got len=%0d drain_dir=%b, expected len=%0d dir=%b",
                     len, active_dir, MAXB, cur);
          end
        end
        gap++;
      end
      out_busy = (busy_left > 0) && (cur == 2'b01);
      in_busy  = (busy_left > 0) && (cur == 2'b10);
      if (busy_left > 0) busy_left--;
    end
    out_busy = 0; in_busy = 0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL both_timeout: %0d grants outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_out_drop;
    logic [1:0] dir;
    bit ok;
    int bad;
    do_reset();
    out_req = 1; flagc_d = 1;
    wait_grant(dir, ok);
    checks++;
    if (!ok || dir !== 2'b01) begin
      errors++;
      $display("FAIL drop_grant: got ok=%0d dir=%b, expected 1 01", ok, dir);
    end
    for (int i = 0; i < 4; i++) tick();
    out_req = 0;
    tick();
    checks++;
    if (stream_out_mode_selected !== 1'b0 || active_dir !== 2'b01) begin
      errors++;
      $display("FAIL drop_drain: got sel=%b dir=%b, expected 0 01", stream_out_mode_selected, active_dir);
    end
    tick();
    checks++;
    if (active_dir !== 2'b00) begin
      errors++;
      $display("FAIL drop_idle: got dir=%b, expected 00", active_dir);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (stream_out_mode_selected || stream_in_mode_selected || faddr !== 2'b11) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL drop_no_regrant: got %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_drain_timeout;
    logic [1:0] dir;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) do_reset();
      out_req = 1; flagc_d = 1;
      wait_grant(dir, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL tmo_grant%0d: got no grant, expected OUT", pass);
      end
      out_req = 0; out_busy = 1;
      for (int i = 0; i < TMO; i++) tick();
      checks++;
      if (drain_timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_early%0d: got err=%b, expected 0", pass, drain_timeout_err);
      end
      if (pass == 1) clr_err = 1;
      tick();
      checks++;
      if (drain_timeout_err !== 1'b1 || active_dir !== 2'b00) begin
        errors++;
        $display("FAIL tmo_set%0d: got err=%b dir=%b, expected 1 00", pass, drain_timeout_err, active_dir);
      end
      clr_err = 1;
      tick();
      checks++;
      if (drain_timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL tmo_clear%0d: got err=%b, expected 0", pass, drain_timeout_err);
      end
      clr_err = 0;
    end
    out_busy = 0;
  endtask

  task automatic test_async_reset;
    logic [1:0] dir;
    bit ok;
    do_reset();
    in_req = 1; flaga_d = 1;
    wait_grant(dir, ok);
    checks++;
    if (!ok || dir !== 2'b10 || faddr !== 2'b00) begin
      errors++;
      $display("FAIL areset_grant: got ok=%0d dir=%b faddr=%b, expected 1 10 00", ok, dir, faddr);
    end
    #3;
    reset_ = 0;
    #1;
    checks++;
    if (stream_in_mode_selected !== 1'b0 || faddr !== 2'b11 || active_dir !== 2'b00) begin
      errors++;
      $display("FAIL areset_async: got in_sel=%b faddr=%b dir=%b, expected 0 11 00",
               stream_in_mode_selected, faddr, active_dir);
    end
    out_req = 1; flagc_d = 1;
    #2;
    reset_ = 1;
    wait_grant(dir, ok);
    checks++;
    if (!ok || dir !== 2'b01 || faddr !== 2'b11) begin
      errors++;
      $display("FAIL areset_priority: got ok=%0d dir=%b faddr=%b, expected 1 01 11", ok, dir, faddr);
    end
  endtask

  task automatic test_flag_gating;
    grant_t e;
    int bad;
    do_reset();
    in_req = 1; flaga_d = 0;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (stream_in_mode_selected || stream_out_mode_selected || faddr !== 2'b11) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gate_blocked: got %0d active cycles, expected 0", bad);
    end
    flaga_d = 1;
    exp_q.push_back('{dir: 2'b10, addr: 2'b00});
    tick();
    checks++;
    if (faddr !== 2'b00) begin
      errors++;
      $display("FAIL gate_turn: got faddr=%b, expected 00", faddr);
    end
    tick(); tick();
    checks++;
    if (stream_in_mode_selected !== 1'b0) begin
      errors++;
      $display("FAIL gate_early: got in_sel=%b, expected 0", stream_in_mode_selected);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if ({stream_in_mode_selected, stream_out_mode_selected} !== e.dir || active_dir !== e.dir || faddr !== e.addr) begin
      errors++;
      $display("FAIL gate_grant: got sel=%b dir=%b faddr=%b, expected %b %b %b",
               {stream_in_mode_selected, stream_out_mode_selected}, active_dir, faddr, e.dir, e.dir, e.addr);
    end
  endtask

  initial begin
    test_reset();
    test_out_only();
    test_both_eligible();
    test_out_drop();
    test_drain_timeout();
    test_async_reset();
    test_flag_gating();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx3_stream_arbiter.md
Name: fx3_stream_arbiter

Overview:
Owns the shared FX3 slave-FIFO bus (2-bit socket address, one bus) and time-shares it between the stream-OUT reader (FX3→FPGA) and the stream-IN writer (FPGA→FX3).
- Grants one direction at a time through the mode-select outputs.
- Drives the socket address (faddr).
- Enforces burst-length fairness and a bus-turnaround gap.
- Watches the subordinate engine's drain with a timeout.
- Sits between the top-level and the per-direction slave-FIFO state machines, all on clk_100.

Parameters:
MAX_OUT_BURST, 1024, max granted cycles for OUT while IN is waiting (≥2)
MAX_IN_BURST, 1024, max granted cycles for IN while OUT is waiting (≥2)
TURN_GAP, 3, idle cycles with both modes deasserted after faddr changes (≥1)
DRAIN_TIMEOUT, 255, max cycles waiting for the engine's busy to clear (≥1)
OUT_ADDR, 2'b11, faddr value for the OUT read socket
IN_ADDR, 2'b00, faddr value for the IN write socket

Ports:
clk_100 input 1 — system clock
reset_ input 1 — async reset, active-low
out_req input 1 — downstream sink can accept stream-OUT data
in_req input 1 — upstream source has stream-IN data
flagc_d input 1 — registered FX3 read-socket data-available flag
flaga_d input 1 — registered FX3 write-socket space-available flag
out_busy input 1 — stream-OUT engine not idle (any of slrd_/sloe_ asserted or flag wait)
in_busy input 1 — stream-IN engine not idle
clr_err input 1 — clears drain_timeout_err
stream_out_mode_selected output 1 — enables the stream-OUT engine
stream_in_mode_selected output 1 — enables the stream-IN engine
faddr output 2 — FX3 socket address
active_dir output 2 — 00 none, 01 OUT, 10 IN
drain_timeout_err output 1 — sticky drain-timeout flag

Behaviour:
- Reset (async, reset_=0) values:
  - both mode selects 0, faddr=OUT_ADDR, active_dir=00, drain_timeout_err=0
  - state IDLE, counters 0, last_dir=IN
- All outputs are registered. The two mode selects are never both 1.
- Eligibility:
  - out_elig = out_req & flagc_d
  - in_elig = in_req & flaga_d
- States and transitions:
  - IDLE:
    - if exactly one direction is eligible, target = that direction.
    - if both are eligible, target = opposite of last_dir.
    - on a target: faddr ← target address, gap_cnt ← 0, go TURN. Otherwise stay.
  - TURN:
    - both mode selects 0; gap_cnt increments each cycle.
    - when gap_cnt = TURN_GAP-1, go ACTIVE, assert the target mode select next cycle, burst_cnt ← 0, last_dir ← target.
    - the gap always applies, including same-direction re-grant.
  - ACTIVE:
    - target mode select = 1; active_dir = target; burst_cnt increments and saturates at MAX-1.
    - go DRAIN (mode select → 0 on the next edge) when either:
      - the own req drops, or
      - burst_cnt = MAX-1 and the other direction is eligible.
    - if the burst limit is reached with the other direction not eligible, stay in ACTIVE (counter saturated).
    - own flag dropping alone does not exit ACTIVE; the engine handles flag stalls itself.
  - DRAIN:
    - mode selects 0; active_dir holds; tmo_cnt increments.
    - go IDLE in the first cycle the granted engine's busy = 0.
    - if tmo_cnt reaches DRAIN_TIMEOUT first: set drain_timeout_err, go IDLE.
    - in both cases active_dir ← 00.
- Error flag:
  - drain_timeout_err clears on clr_err=1.
  - a simultaneous set and clear resolves to set.
- Faddr rules:
  - faddr changes only on the IDLE→TURN edge; it is stable throughout TURN/ACTIVE/DRAIN.
  - faddr never changes while either busy is 1 and that engine's mode is selected.
- Other boundary cases:
  - req rising during TURN does not alter target.
  - a req drop during TURN is resolved in ACTIVE: it exits to DRAIN on the first ACTIVE cycle.
  - reset mid-burst: immediate return to reset values; engines see mode select 0 asynchronously.
  - illegal state encoding → IDLE.

Test Plan:
- OUT only: out_req=1, flagc_d=1, in_req=0 → faddr=11 one cycle after req; stream_out_mode_selected=1 after exactly 3 TURN cycles; stays 1 indefinitely with the burst count saturated.
- Both eligible from reset: out_elig=in_elig=1, MAX_OUT_BURST=8 → OUT granted first for 8 cycles, then DRAIN; out_busy held 2 cycles → IDLE, TURN (3 cycles, faddr=00), IN granted; grants continue alternating OUT/IN.
- OUT req drop: out_req 1→0 at burst cycle 5 → mode select 0 next edge; out_busy cleared → IDLE; no IN grant if in_req=0.
- Drain timeout: DRAIN_TIMEOUT=4, out_busy stuck 1 → drain_timeout_err=1 after 4 DRAIN cycles, state IDLE; clr_err=1 on the same cycle as a new timeout → flag stays 1.
- Async reset mid-ACTIVE: reset_=0 while IN granted → stream_in_mode_selected=0 and faddr=11 without waiting for a clock edge; after release, OUT-first priority restored.
- Flag gating: in_req=1 with flaga_d=0 → no grant; flaga_d rises → TURN begins on the next edge.
